// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial adder.
// The requester uses the master modport; the adder uses the slave modport.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell with a registered carry, LSB first.
// Computes {cout, sum} = a + b + cin over WIDTH clocks with a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             s_bit;
    logic             c_next;

    always_comb begin
        s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d   = {s_bit, acc_q[WIDTH-1:1]};
                carry_d = c_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake outputs are registered versions of the next-state decode.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8();
    serial_adder_if #(.WIDTH(16)) bus16();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // lat counts falling edges after the accepting edge (1 = first cycle after it).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input bit inject, output int lat, output int busy_cyc);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.cin = cin;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = ~a;
        bus8.b = ~b;
        bus8.cin = ~cin;
        lat = 1;
        busy_cyc = 0;
        while (!bus8.done && lat < 40) begin
            if (bus8.busy) busy_cyc++;
            if (inject && lat == 3) begin
                bus8.start = 1'b1;
                bus8.a = 8'h11;
                bus8.b = 8'h22;
                bus8.cin = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus8.start = 1'b0;
        if (!bus8.done) check("op8_done_timeout", bus8.done, 1'b1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, output int lat);
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a = a;
        bus16.b = b;
        bus16.cin = cin;
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.a = ~a;
        bus16.b = ~b;
        lat = 1;
        while (!bus16.done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!bus16.done) check("op16_done_timeout", bus16.done, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, cyc, t1, t2, extra_done, extra_busy;
        bit hold_ok;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        logic        rc;
        logic [8:0]  exp9;
        logic [16:0] exp17;

        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus8.busy, 1'b0);
        check("rst_done", bus8.done, 1'b0);
        check("rst_sum",  bus8.sum,  8'h00);
        check("rst_cout", bus8.cout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", bus8.busy, 1'b0);

        // Basic add with latency and busy length
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bc);
        check("t1_latency", lat, 9);
        check("t1_busy_cycles", bc, 8);
        check("t1_sum", bus8.sum, 8'h96);
        check("t1_cout", bus8.cout, 1'b0);
        @(negedge clk);
        check("t1_done_one_cycle", bus8.done, 1'b0);

        op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bc);
        check("t2_sum", bus8.sum, 8'h00);
        check("t2_cout", bus8.cout, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bc);
        check("t3_sum", bus8.sum, 8'hFF);
        check("t3_cout", bus8.cout, 1'b1);

        // start pulsed mid-RUN must be ignored and not queued
        op8(8'h5A, 8'h3C, 1'b0, 1'b1, lat, bc);
        check("t4_latency", lat, 9);
        check("t4_sum", bus8.sum, 8'h96);
        check("t4_cout", bus8.cout, 1'b0);
        extra_done = 0;
        extra_busy = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus8.done) extra_done++;
            if (bus8.busy) extra_busy++;
        end
        check("t4_extra_done", extra_done, 0);
        check("t4_extra_busy", extra_busy, 0);

        // Reset in cycle 4 of RUN
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", bus8.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", bus8.busy, 1'b0);
        check("t5_rst_done", bus8.done, 1'b0);
        check("t5_rst_sum",  bus8.sum,  8'h00);
        check("t5_rst_cout", bus8.cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus8.done) extra_done++;
        end
        check("t5_no_done_after_rst", extra_done, 0);
        op8(8'h01, 8'h01, 1'b1, 1'b0, lat, bc);
        check("t5_sum", bus8.sum, 8'h03);
        check("t5_cout", bus8.cout, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus8.done && cyc < 40);
        t1 = cyc;
        check("t6_first_latency", t1, 9);
        check("t6_first_sum", bus8.sum, 8'h30);
        check("t6_first_cout", bus8.cout, 1'b0);
        bus8.a = 8'h80; bus8.b = 8'h80;
        hold_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus8.done && bus8.sum !== 8'h30) hold_ok = 1'b0;
        end while (!bus8.done && cyc < 80);
        t2 = cyc;
        bus8.start = 1'b0;
        check("t6_done_spacing", t2 - t1, 10);
        check("t6_sum_held", hold_ok, 1'b1);
        check("t6_second_sum", bus8.sum, 8'h00);
        check("t6_second_cout", bus8.cout, 1'b1);

        for (int unsigned i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            op8(ra, rb, rc, 1'b0, lat, bc);
            check("rand8", {bus8.cout, bus8.sum}, exp9);
        end

        for (int unsigned i = 0; i < 1000; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            rc = 1'($urandom);
            exp17 = {1'b0, wa} + {1'b0, wb} + {16'h0000, rc};
            op16(wa, wb, rc, lat);
            if (i == 0) check("rand16_latency", lat, 17);
            check("rand16", {bus16.cout, bus16.sum}, exp17);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
